// File: rtl/vx_mem_tag_remap_arb.sv
`default_nettype none
// ============================================================================
// Module   : vx_mem_tag_remap_arb
// Purpose  : Round-robin arbiter that merges NUM_REQS L1 memory request
//            channels onto one L2 port. Each read's wide {channel, tag} is
//            parked in a small tag table and replaced by a compact slot ID.
//            The L2 response slot ID is used to restore the original channel
//            and tag.
// Ports    : clk, reset_n (async, active low)
//            req_*      : per-channel L1 requests (valid/ready, packed buses)
//            mem_req_*  : registered L2 request (tag = slot ID, 0 for writes)
//            mem_rsp_*  : L2 response (tag = slot ID)
//            rsp_*      : registered one-hot L1 response with restored tag
//            perf_*     : present only when TAG_REMAP_PERF_EN is defined
// Options  : TAG_REMAP_PERF_EN - adds saturating stall/read counters and a
//            peak in-flight tracker.
// Revision : 1.0 - initial release
// ============================================================================
module vx_mem_tag_remap_arb #(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 512,
  parameter int IN_TAG_W   = 16,
  parameter int TAG_SLOTS  = 16,
  parameter int SLOT_W     = $clog2(TAG_SLOTS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQS-1:0]              req_valid,
  input  logic [NUM_REQS-1:0]              req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQS*DATA_WIDTH/8-1:0] req_byteen,
  input  logic [NUM_REQS*IN_TAG_W-1:0]     req_tag,
  output logic [NUM_REQS-1:0]              req_ready,
  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [DATA_WIDTH/8-1:0]          mem_req_byteen,
  output logic [SLOT_W-1:0]                mem_req_tag,
  input  logic                             mem_req_ready,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  input  logic [SLOT_W-1:0]                mem_rsp_tag,
  output logic                             mem_rsp_ready,
  output logic [NUM_REQS-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [IN_TAG_W-1:0]              rsp_tag,
`ifdef TAG_REMAP_PERF_EN
  output logic [31:0]                      perf_stall_cycles,
  output logic [31:0]                      perf_reads,
  output logic [SLOT_W:0]                  perf_peak_inflight,
`endif
  input  logic [NUM_REQS-1:0]              rsp_ready
);

  localparam int CH_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int BE_W = DATA_WIDTH / 8;

  // Per-channel views of the packed request buses
  logic [ADDR_WIDTH-1:0] w_addr [NUM_REQS];
  logic [DATA_WIDTH-1:0] w_data [NUM_REQS];
  logic [BE_W-1:0]       w_be   [NUM_REQS];
  logic [IN_TAG_W-1:0]   w_tag  [NUM_REQS];

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_unpack
    assign w_addr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_be[i]   = req_byteen[i*BE_W +: BE_W];
    assign w_tag[i]  = req_tag[i*IN_TAG_W +: IN_TAG_W];
  end

  // State
  logic [CH_W-1:0]       ptr_q;
  logic [TAG_SLOTS-1:0]  busy_q, busy_d;
  logic [CH_W-1:0]       tbl_ch_q  [TAG_SLOTS];
  logic [IN_TAG_W-1:0]   tbl_tag_q [TAG_SLOTS];

  logic                  mreq_valid_q;
  logic                  mreq_rw_q;
  logic [ADDR_WIDTH-1:0] mreq_addr_q;
  logic [DATA_WIDTH-1:0] mreq_data_q;
  logic [BE_W-1:0]       mreq_be_q;
  logic [SLOT_W-1:0]     mreq_tag_q;

  logic [NUM_REQS-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [IN_TAG_W-1:0]   rsp_tag_q;

  // Free-slot priority encoder (lowest index wins)
  logic                  w_full;
  logic [SLOT_W-1:0]     w_free_idx;

  assign w_full = &busy_q;

  always_comb begin
    w_free_idx = '0;
    for (int s = TAG_SLOTS - 1; s >= 0; s--) begin
      if (!busy_q[s]) w_free_idx = SLOT_W'(s);
    end
  end

  // Round-robin arbitration; reads are only eligible while a slot is free
  logic [NUM_REQS-1:0] w_eligible;
  logic                w_grant_valid;
  logic [CH_W-1:0]     w_grant_idx;
  logic                w_can_load;
  logic                w_grant_fire;
  logic                w_alloc;

  assign w_eligible = req_valid & (req_rw | {NUM_REQS{~w_full}});

  always_comb begin
    int idx;
    idx           = 0;
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      if (!w_grant_valid && w_eligible[idx]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = CH_W'(idx);
      end
    end
  end

  assign w_can_load   = ~mreq_valid_q | mem_req_ready;
  assign w_grant_fire = reset_n & w_grant_valid & w_can_load;
  assign w_alloc      = w_grant_fire & ~req_rw[w_grant_idx];

  always_comb begin
    req_ready = '0;
    if (w_grant_fire) req_ready[w_grant_idx] = 1'b1;
  end

  // Response side
  logic                w_rsp_draining;
  logic                w_rsp_accept;
  logic                w_rsp_hit;
  logic [NUM_REQS-1:0] w_rsp_onehot;

  assign w_rsp_draining = |(rsp_valid_q & rsp_ready);
  assign mem_rsp_ready  = reset_n & (~|rsp_valid_q | w_rsp_draining);
  assign w_rsp_accept   = mem_rsp_valid & mem_rsp_ready;
  // A response naming a free slot is dropped without touching the bitmap
  assign w_rsp_hit      = w_rsp_accept & busy_q[mem_rsp_tag];

  always_comb begin
    w_rsp_onehot = '0;
    w_rsp_onehot[tbl_ch_q[mem_rsp_tag]] = 1'b1;
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    if (w_rsp_hit)           rsp_valid_d = w_rsp_onehot;
    else if (w_rsp_draining) rsp_valid_d = '0;
  end

  // Free and alloc on the same edge never collide: alloc picks from the
  // pre-free bitmap, so it can only choose a slot that is already free.
  always_comb begin
    busy_d = busy_q;
    if (w_rsp_hit) busy_d[mem_rsp_tag] = 1'b0;
    if (w_alloc)   busy_d[w_free_idx]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      busy_q       <= '0;
      mreq_valid_q <= 1'b0;
      mreq_rw_q    <= 1'b0;
      mreq_addr_q  <= '0;
      mreq_data_q  <= '0;
      mreq_be_q    <= '0;
      mreq_tag_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_tag_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      if (w_grant_fire) begin
        ptr_q        <= (w_grant_idx == CH_W'(NUM_REQS - 1)) ? '0 : w_grant_idx + 1'b1;
        mreq_valid_q <= 1'b1;
        mreq_rw_q    <= req_rw[w_grant_idx];
        mreq_addr_q  <= w_addr[w_grant_idx];
        mreq_data_q  <= w_data[w_grant_idx];
        mreq_be_q    <= w_be[w_grant_idx];
        mreq_tag_q   <= w_alloc ? w_free_idx : '0;
      end else if (mem_req_ready) begin
        mreq_valid_q <= 1'b0;
      end
      if (w_rsp_hit) begin
        rsp_data_q <= mem_rsp_data;
        rsp_tag_q  <= tbl_tag_q[mem_rsp_tag];
      end
    end
  end

  // Tag table contents are only meaningful while the busy bit is set
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      tbl_ch_q[w_free_idx]  <= w_grant_idx;
      tbl_tag_q[w_free_idx] <= w_tag[w_grant_idx];
    end
  end

  assign mem_req_valid  = mreq_valid_q;
  assign mem_req_rw     = mreq_rw_q;
  assign mem_req_addr   = mreq_addr_q;
  assign mem_req_data   = mreq_data_q;
  assign mem_req_byteen = mreq_be_q;
  assign mem_req_tag    = mreq_tag_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_tag        = rsp_tag_q;

`ifdef TAG_REMAP_PERF_EN
  logic [31:0]   perf_stall_q, perf_reads_q;
  logic [SLOT_W:0] perf_peak_q;
  logic [SLOT_W:0] w_inflight;
  logic            w_read_blocked;

  always_comb begin
    w_inflight = '0;
    for (int s = 0; s < TAG_SLOTS; s++) begin
      w_inflight = w_inflight + (SLOT_W+1)'(busy_q[s]);
    end
  end

  assign w_read_blocked = w_full & |(req_valid & ~req_rw);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_q <= '0;
      perf_reads_q <= '0;
      perf_peak_q  <= '0;
    end else begin
      if (w_read_blocked && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 1'b1;
      if (w_alloc && !(&perf_reads_q))        perf_reads_q <= perf_reads_q + 1'b1;
      if (w_inflight > perf_peak_q)           perf_peak_q  <= w_inflight;
    end
  end

  assign perf_stall_cycles  = perf_stall_q;
  assign perf_reads         = perf_reads_q;
  assign perf_peak_inflight = perf_peak_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n && w_rsp_accept) begin
      assert (busy_q[mem_rsp_tag]);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_mem_tag_remap_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_mem_tag_remap_arb
// Purpose  : Directed self-checking bench for vx_mem_tag_remap_arb
//            (4 channels, 16 slots, 32-bit data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_mem_tag_remap_arb;

  localparam int NR = 4;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int TW = 16;
  localparam int NS = 16;
  localparam int SW = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NR-1:0]    req_valid, req_rw, req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR*DW/8-1:0] req_byteen;
  logic [NR*TW-1:0] req_tag;
  logic             mem_req_valid, mem_req_rw, mem_req_ready;
  logic [AW-1:0]    mem_req_addr;
  logic [DW-1:0]    mem_req_data;
  logic [DW/8-1:0]  mem_req_byteen;
  logic [SW-1:0]    mem_req_tag;
  logic             mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0]    mem_rsp_data;
  logic [SW-1:0]    mem_rsp_tag;
  logic [NR-1:0]    rsp_valid, rsp_ready;
  logic [DW-1:0]    rsp_data;
  logic [TW-1:0]    rsp_tag;

  logic [TW-1:0]    tb_tag [NR];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) req_tag[i*TW +: TW] = tb_tag[i];
  end

  vx_mem_tag_remap_arb #(
    .NUM_REQS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IN_TAG_W(TW), .TAG_SLOTS(NS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .req_byteen(req_byteen), .req_tag(req_tag), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  rv, rw;
    logic        mrr, mrv;
    logic [3:0]  mtag, rrdy;
    logic [3:0]  e_rr;
    logic        e_mv;
    logic [3:0]  e_mtag;
    logic        e_mrdy;
    logic [3:0]  e_rv;
    logic [15:0] e_rtag;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] rv, rw, input logic mrr, mrv,
                              input logic [3:0] mtag, rrdy, e_rr, input logic e_mv,
                              input logic [3:0] e_mtag, input logic e_mrdy,
                              input logic [3:0] e_rv, input logic [15:0] e_rtag);
    vec_t v;
    v.rv = rv; v.rw = rw; v.mrr = mrr; v.mrv = mrv; v.mtag = mtag; v.rrdy = rrdy;
    v.e_rr = e_rr; v.e_mv = e_mv; v.e_mtag = e_mtag; v.e_mrdy = e_mrdy;
    v.e_rv = e_rv; v.e_rtag = e_rtag;
    return v;
  endfunction

  task automatic idle_inputs();
    req_valid = '0; req_rw = '0; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_tag = '0; mem_rsp_data = '0; rsp_ready = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    req_valid = 4'hF;
    reset_n = 1'b0;
    #1;
    chk("reset_outputs",
        {32'd0, req_ready, mem_req_valid, mem_req_tag, mem_rsp_ready, rsp_valid, rsp_tag},
        64'd0);
    repeat (2) @(negedge clk);
    req_valid = '0;
    reset_n = 1'b1;
  endtask

  vec_t          vecs [19];
  logic [15:0]   exp_tag [NS];
  logic [3:0]    exp_ch  [NS];
  logic [3:0]    oh;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_addr   = {26'h103, 26'h102, 26'h101, 26'h100};
    req_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    req_byteen = '1;
    tb_tag[0] = 16'h00AB; tb_tag[1] = 16'h1111; tb_tag[2] = 16'h2222; tb_tag[3] = 16'h3333;

    //            rv   rw   mrr mrv mtag rrdy | e_rr e_mv e_mtag e_mrdy e_rv e_rtag
    vecs[0]  = mk(4'h0,4'h0,1,0,4'd0,4'h0, 4'h0,0,4'd0,1,4'h0,16'h0);
    vecs[1]  = mk(4'h1,4'h0,1,0,4'd0,4'h0, 4'h1,0,4'd0,1,4'h0,16'h0);
    vecs[2]  = mk(4'h0,4'h0,1,0,4'd0,4'h0, 4'h0,1,4'd0,1,4'h0,16'h0);
    vecs[3]  = mk(4'h0,4'h0,1,0,4'd0,4'h0, 4'h0,0,4'd0,1,4'h0,16'h0);
    vecs[4]  = mk(4'h0,4'h0,1,0,4'd0,4'h0, 4'h0,0,4'd0,1,4'h0,16'h0);
    vecs[5]  = mk(4'h0,4'h0,1,1,4'd0,4'h1, 4'h0,0,4'd0,1,4'h0,16'h0);
    vecs[6]  = mk(4'h0,4'h0,1,0,4'd0,4'h1, 4'h0,0,4'd0,1,4'h1,16'h00AB);
    vecs[7]  = mk(4'hF,4'h0,1,0,4'd0,4'hF, 4'h2,0,4'd0,1,4'h0,16'h0);
    vecs[8]  = mk(4'hF,4'h0,1,0,4'd0,4'hF, 4'h4,1,4'd0,1,4'h0,16'h0);
    vecs[9]  = mk(4'hF,4'h0,1,0,4'd0,4'hF, 4'h8,1,4'd1,1,4'h0,16'h0);
    vecs[10] = mk(4'hF,4'h0,1,0,4'd0,4'hF, 4'h1,1,4'd2,1,4'h0,16'h0);
    vecs[11] = mk(4'hF,4'h0,1,0,4'd0,4'hF, 4'h2,1,4'd3,1,4'h0,16'h0);
    vecs[12] = mk(4'h0,4'h0,1,0,4'd0,4'h0, 4'h0,1,4'd4,1,4'h0,16'h0);
    vecs[13] = mk(4'h4,4'h0,0,0,4'd0,4'h0, 4'h4,0,4'd0,1,4'h0,16'h0);
    vecs[14] = mk(4'h4,4'h0,0,0,4'd0,4'h0, 4'h0,1,4'd5,1,4'h0,16'h0);
    vecs[15] = mk(4'h4,4'h0,1,0,4'd0,4'h0, 4'h4,1,4'd5,1,4'h0,16'h0);
    vecs[16] = mk(4'h0,4'h0,1,0,4'd0,4'h0, 4'h0,1,4'd6,1,4'h0,16'h0);
    vecs[17] = mk(4'h8,4'h8,1,0,4'd0,4'h0, 4'h8,0,4'd0,1,4'h0,16'h0);
    vecs[18] = mk(4'h0,4'h0,1,0,4'd0,4'h0, 4'h0,1,4'd0,1,4'h0,16'h0);

    reset_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Table-driven: single read round trip, round robin, backpressure, write
    for (int i = 0; i < 19; i++) begin
      req_valid = vecs[i].rv; req_rw = vecs[i].rw; mem_req_ready = vecs[i].mrr;
      mem_rsp_valid = vecs[i].mrv; mem_rsp_tag = vecs[i].mtag; rsp_ready = vecs[i].rrdy;
      mem_rsp_data = 32'hCAFE0000;
      #1;
      chk($sformatf("vec%0d", i),
          {34'd0, req_ready, mem_req_valid, (vecs[i].e_mv ? mem_req_tag : 4'd0),
           mem_rsp_ready, rsp_valid, (vecs[i].e_rv != 0 ? rsp_tag : 16'd0)},
          {34'd0, vecs[i].e_rr, vecs[i].e_mv, vecs[i].e_mtag,
           vecs[i].e_mrdy, vecs[i].e_rv, vecs[i].e_rtag});
      @(negedge clk);
    end

    // Fill all 16 slots with rotating channels
    do_reset();
    for (int k = 0; k < NS; k++) begin
      for (int c = 0; c < NR; c++) tb_tag[c] = 16'(16'h1000 * (c + 1) + k);
      req_valid = 4'hF; req_rw = 4'h0; mem_req_ready = 1'b1;
      exp_ch[k]  = 4'(k % NR);
      exp_tag[k] = 16'(16'h1000 * (k % NR + 1) + k);
      #1;
      oh = 4'b0001 << (k % NR);
      chk($sformatf("fill_grant%0d", k), {60'd0, req_ready}, {60'd0, oh});
      if (k > 0) chk($sformatf("fill_slot%0d", k), {60'd0, mem_req_tag}, 64'(k - 1));
      @(negedge clk);
    end

    // Full: read stalls
    req_valid = 4'h1; req_rw = 4'h0;
    #1;
    chk("full_read_stall", {60'd0, req_ready}, 64'h0);
    @(negedge clk);

    // Full: ch2 write still passes
    req_valid = 4'h5; req_rw = 4'h4;
    #1;
    chk("full_write_grant", {60'd0, req_ready}, 64'h4);
    @(negedge clk);

    // Write on L2 port; response for slot 5 coincides with pending read
    req_valid = 4'h1; req_rw = 4'h0;
    mem_rsp_valid = 1'b1; mem_rsp_tag = 4'd5; mem_rsp_data = 32'hD0000005; rsp_ready = 4'h0;
    #1;
    chk("write_on_l2", {32'd0, 1'b0, mem_req_valid, mem_req_rw, mem_req_tag, mem_req_addr},
        {32'd0, 1'b0, 1'b1, 1'b1, 4'd0, 26'h102});
    chk("full_coincide_stall", {59'd0, mem_rsp_ready, req_ready}, {59'd0, 1'b1, 4'h0});
    @(negedge clk);

    mem_rsp_valid = 1'b0; rsp_ready = 4'h2; tb_tag[0] = 16'hABCD;
    #1;
    chk("slot5_reuse_grant", {60'd0, req_ready}, 64'h1);
    chk("slot5_rsp", {12'd0, rsp_valid, rsp_tag, rsp_data},
        {12'd0, 4'b0001 << exp_ch[5], exp_tag[5], 32'hD0000005});
    @(negedge clk);

    req_valid = 4'h0; rsp_ready = 4'h0;
    #1;
    chk("slot5_reissued", {58'd0, mem_req_valid, mem_req_rw, mem_req_tag},
        {58'd0, 1'b1, 1'b0, 4'd5});
    chk("rsp_drained", {60'd0, rsp_valid}, 64'h0);
    exp_ch[5] = 4'd0; exp_tag[5] = 16'hABCD;
    @(negedge clk);

    // Out-of-order responses 3, 1, 2 with backpressure
    mem_rsp_valid = 1'b1; mem_rsp_tag = 4'd3; mem_rsp_data = 32'hD0000003; rsp_ready = 4'h0;
    #1;
    chk("ooo_accept3", {63'd0, mem_rsp_ready}, 64'h1);
    @(negedge clk);
    mem_rsp_tag = 4'd1; mem_rsp_data = 32'hD0000001;
    for (int h = 0; h < 2; h++) begin
      #1;
      chk($sformatf("ooo_hold3_%0d", h), {11'd0, mem_rsp_ready, rsp_valid, rsp_tag, rsp_data},
          {11'd0, 1'b0, 4'b0001 << exp_ch[3], exp_tag[3], 32'hD0000003});
      @(negedge clk);
    end
    rsp_ready = 4'b0001 << exp_ch[3];
    #1;
    chk("ooo_drain3", {63'd0, mem_rsp_ready}, 64'h1);
    @(negedge clk);
    mem_rsp_tag = 4'd2; mem_rsp_data = 32'hD0000002; rsp_ready = 4'b0001 << exp_ch[1];
    #1;
    chk("ooo_rsp1", {12'd0, rsp_valid, rsp_tag, rsp_data},
        {12'd0, 4'b0001 << exp_ch[1], exp_tag[1], 32'hD0000001});
    @(negedge clk);
    mem_rsp_valid = 1'b0; rsp_ready = 4'b0001 << exp_ch[2];
    #1;
    chk("ooo_rsp2", {12'd0, rsp_valid, rsp_tag, rsp_data},
        {12'd0, 4'b0001 << exp_ch[2], exp_tag[2], 32'hD0000002});
    @(negedge clk);
    rsp_ready = 4'h0;

    // Reset mid-burst with 6 slots busy
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req_valid = 4'hF; req_rw = 4'h0; mem_req_ready = 1'b1;
      @(negedge clk);
    end
    #2;
    chk("pre_reset_busy", {58'd0, mem_req_valid, 1'b0, mem_req_tag}, {58'd0, 1'b1, 1'b0, 4'd5});
    reset_n = 1'b0;
    #1;
    chk("midburst_reset", {2'd0, req_ready, mem_req_valid, mem_req_tag, mem_req_addr,
                           mem_rsp_ready, rsp_valid, rsp_tag},
        64'd0);
    @(negedge clk);
    reset_n = 1'b1; req_valid = 4'h1;
    #1;
    chk("post_reset_grant", {60'd0, req_ready}, 64'h1);
    @(negedge clk);
    req_valid = 4'h0;
    #1;
    chk("post_reset_slot0", {59'd0, mem_req_valid, mem_req_tag}, {59'd0, 1'b1, 4'd0});
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
